// File: rtl/i2s_tx.sv
// i2s_tx: serializes mono samples into a stereo I2S frame through a one-deep holding register.
// Build macro I2S_TX_MUTE_ON_UNDERRUN_EN: an underrun frame carries silence instead of repeating the last sample.
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_req,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int PW  = $clog2(4 * SAMPLE_WIDTH);
  localparam int SRW = 2 * SAMPLE_WIDTH;

  logic [PW-1:0]           p;
  logic [SRW-1:0]          sr;
  logic [SAMPLE_WIDTH-1:0] hold;
  logic [SAMPLE_WIDTH-1:0] last;
  logic                    hold_full;
  logic                    req_q;
  logic                    und_q;
  logic                    ovr_q;
  logic                    load_edge;
  logic                    shift_edge;

  // Loading while leaving p=1 puts the MSB out one slot after lrclk changes.
  assign load_edge  = (p == PW'(1));
  assign shift_edge = p[0] && !load_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else begin
      p <= p + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      last  <= '0;
      req_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      req_q <= 1'b0;
      und_q <= 1'b0;
      if (load_edge) begin
        if (hold_full) begin
          sr    <= {hold, hold};
          last  <= hold;
          req_q <= 1'b1;
        end else begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          sr    <= '0;
`else
          sr    <= {last, last};
`endif
          und_q <= 1'b1;
        end
      end else if (shift_edge) begin
        sr <= {sr[SRW-2:0], 1'b0};
      end
    end
  end

  // A write landing on the load edge is kept for the next frame; the old sample is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (sample_valid) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
        if (hold_full && !load_edge) begin
          ovr_q <= 1'b1;
        end
      end else if (load_edge) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign bclk       = p[0];
  assign lrclk      = p[PW-1];
  assign sdata      = sr[SRW-1];
  assign sample_req = req_q;
  assign underrun   = und_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: directed writes push expected frames into a queue; a monitor deserializes
// each frame window (p=2 .. p=1 of the next frame) and compares word and status pulses.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_req;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;
  logic        overrun;

  i2s_tx #(.SAMPLE_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_req   (sample_req),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    bit          req;
    bit          und;
    int          ovr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference frame position, restarted by reset exactly like the design's phase.
  logic [5:0] tp;
  logic [7:0] fr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp <= '0;
      fr <= '0;
    end else begin
      tp <= tp + 6'd1;
      if (tp == 6'd63) fr <= fr + 8'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (frame %0d p %0d)", name, act, exp, fr, tp);
  endtask

  task automatic push(input logic [31:0] w, input bit r, input bit u, input int o);
    exp_t e;
    e.word = w; e.req = r; e.und = u; e.ovr = o;
    q.push_back(e);
  endtask

  task automatic wait_fp(input int f, input int pp);
    int n = 0;
    @(negedge clk);
    while (!(int'(fr) == f && int'(tp) == pp) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_chk++;
      $display("FAIL wait_timeout: never reached frame %0d p %0d", f, pp);
    end
  endtask

  task automatic write_at(input int f, input int pp, input logic [15:0] d);
    wait_fp(f, pp);
    sample_in    = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outputs"}, {26'd0, bclk, lrclk, sdata, sample_req, underrun, overrun}, 32'd0);
  endtask

  // Monitor: one window per frame, bits taken while bclk is high.
  bit          win_act = 0;
  logic [31:0] word;
  bit          got_req;
  bit          got_und;
  int          got_ovr;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      win_act = 0;
    end else begin
      chk("bclk", {31'd0, bclk}, {31'd0, tp[0]});
      chk("lrclk", {31'd0, lrclk}, {31'd0, tp[5]});
      if (tp == 6'd2) begin
        win_act = 1;
        word    = '0;
        got_req = sample_req;
        got_und = underrun;
        got_ovr = 0;
      end else if (sample_req || underrun) begin
        chk("pulse_at_p2", {26'd0, tp}, 32'd2);
      end
      if (win_act && overrun) got_ovr++;
      if (win_act && tp[0]) word = {word[30:0], sdata};
      if (win_act && tp == 6'd1) begin
        win_act = 0;
        if (q.size() == 0) begin
          chk("unexpected_frame", word, 32'hxxxx_xxxx);
        end else begin
          e = q.pop_front();
          chk("frame_word", word, e.word);
          chk("sample_req", {31'd0, got_req}, {31'd0, e.req});
          chk("underrun", {31'd0, got_und}, {31'd0, e.und});
          chk("overrun_count", got_ovr, e.ovr);
        end
      end
    end
  end

  logic [31:0] rep_word;

  initial begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    rep_word = 32'h0000_0000;
`else
    rep_word = 32'h5678_5678;
`endif
    push(32'h0, 0, 1, 0);            // frames 0,1: idle, underrun with zero data
    push(32'h0, 0, 1, 0);
    push(32'hA5C3_A5C3, 1, 0, 1);    // frame 2 also sees the overrun from the 8000/7FFF pair
    push(32'h7FFF_7FFF, 1, 0, 0);
    push(32'h1234_1234, 1, 0, 0);
    push(32'h5678_5678, 1, 0, 0);
    push(rep_word, 0, 1, 0);
    push(32'h0F0F_0F0F, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    write_at(1, 40, 16'hA5C3);
    write_at(2, 10, 16'h8000);
    write_at(2, 20, 16'h7FFF);
    write_at(3, 30, 16'h1234);
    write_at(4, 1, 16'h5678);
    write_at(6, 50, 16'h0F0F);

    wait_fp(8, 37);
    chk("pre_reset_lrclk", {31'd0, lrclk}, 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) @(negedge clk);
    chk_all_zero("held_reset");
    rst = 1'b0;
    push(32'h0, 0, 1, 0);
    push(32'hBEEF_BEEF, 1, 0, 0);
    write_at(1, 0, 16'hBEEF);
    wait_fp(1, 2);
    chk("latency_msb", {31'd0, sdata}, 32'd1);

    wait_fp(2, 4);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
